// File: rtl/hit_pkg.sv
// Shared types and constants for the hit record builder.
// Record length depends on HIT_REC_TS_EN (timestamp words appended when defined).
package hit_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIT  = 2'd1,
      S_SEND = 2'd2
   } state_e;

   localparam logic [2:0] W_ID   = 3'd0;
   localparam logic [2:0] W_PEAK = 3'd1;
   localparam logic [2:0] W_DUR  = 3'd2;
   localparam logic [2:0] W_TSH  = 3'd3;
   localparam logic [2:0] W_TSL  = 3'd4;

`ifdef HIT_REC_TS_EN
   localparam int unsigned REC_LEN = 5;
`else
   localparam int unsigned REC_LEN = 3;
`endif

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   function automatic logic [15:0] umax16(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hit_record_if.sv
// Sample/status inputs and record stream outputs of the hit record builder.
// slave = builder side, master = producer/consumer side.
interface hit_record_if;
   logic [15:0] sm_data;
   logic        sm_vld;
   logic        stu_now_hit;
   logic [15:0] stu_hit_id;
   logic        cfg_en;
   logic [15:0] rec_data;
   logic        rec_vld;
   logic        rec_last;
   logic        rec_rdy;
   logic        stu_rec_busy;
   logic [15:0] stu_rec_drop;

   modport slave (
      input  sm_data, sm_vld, stu_now_hit, stu_hit_id, cfg_en, rec_rdy,
      output rec_data, rec_vld, rec_last, stu_rec_busy, stu_rec_drop
   );

   modport master (
      output sm_data, sm_vld, stu_now_hit, stu_hit_id, cfg_en, rec_rdy,
      input  rec_data, rec_vld, rec_last, stu_rec_busy, stu_rec_drop
   );
endinterface

// File: rtl/hit_rec_ser.sv
// Word serializer: loads captured fields and streams them out over valid/ready.
// Timestamp words and the i_ts port exist only with HIT_REC_TS_EN.
module hit_rec_ser
   import hit_pkg::*;
(
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [15:0] i_id,
   input  logic [15:0] i_peak,
   input  logic [15:0] i_dur,
`ifdef HIT_REC_TS_EN
   input  logic [31:0] i_ts,
`endif
   input  logic        i_rec_rdy,
   output logic [15:0] o_rec_data,
   output logic        o_rec_vld,
   output logic        o_rec_last,
   output logic        o_done
);

   localparam logic [2:0] LastIdx = 3'(REC_LEN - 1);

   logic [2:0]  r_idx;
   logic [15:0] r_data;
   logic        r_vld;
   logic        r_last;
   logic [2:0]  w_idx_nxt;
   logic [15:0] w_word_nxt;

   assign w_idx_nxt = r_idx + 3'd1;

   always_comb begin
      w_word_nxt = '0;
      case (w_idx_nxt)
         W_PEAK:  w_word_nxt = i_peak;
         W_DUR:   w_word_nxt = i_dur;
`ifdef HIT_REC_TS_EN
         W_TSH:   w_word_nxt = i_ts[31:16];
         W_TSL:   w_word_nxt = i_ts[15:0];
`endif
         default: w_word_nxt = '0;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= W_ID;
         r_data <= '0;
         r_vld  <= 1'b0;
         r_last <= 1'b0;
      end else if (i_load) begin
         r_idx  <= W_ID;
         r_data <= i_id;
         r_vld  <= 1'b1;
         r_last <= 1'b0;
      end else if (r_vld && i_rec_rdy) begin
         if (r_last) begin
            r_idx  <= W_ID;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
         end else begin
            r_idx  <= w_idx_nxt;
            r_data <= w_word_nxt;
            r_last <= (w_idx_nxt == LastIdx);
         end
      end
   end

   assign o_rec_data = r_data;
   assign o_rec_vld  = r_vld;
   assign o_rec_last = r_last;
   assign o_done     = r_vld & i_rec_rdy & r_last;

endmodule

// File: rtl/hit_record.sv
// Hit record builder top: edge detect, field capture, drop counter, serializer.
// Define HIT_REC_TS_EN to add the free-running timestamp and 5-word records.
module hit_record
   import hit_pkg::*;
(
   input  logic     clk_sys,
   input  logic     rst_n,
   hit_record_if.slave bus
);

   state_e      r_state;
   state_e      w_state_nxt;
   logic        r_busy;
   logic        r_hit_d;
   logic [15:0] r_last_smp;
   logic [15:0] r_id;
   logic [15:0] r_peak;
   logic [15:0] r_dur;
   logic [15:0] r_drop;
   logic        w_rise;
   logic        w_capture;
   logic        w_accum;
   logic        w_load;
   logic        w_drop_inc;
   logic        w_done;

`ifdef HIT_REC_TS_EN
   logic [31:0] r_ts;
   logic [31:0] r_ts_q;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_ts   <= '0;
         r_ts_q <= '0;
      end else begin
         r_ts <= r_ts + 32'd1;
         if (w_capture) r_ts_q <= r_ts;
      end
   end
`endif

   assign w_rise = bus.stu_now_hit & ~r_hit_d;

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_accum     = 1'b0;
      w_load      = 1'b0;
      w_drop_inc  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_rise && bus.cfg_en) begin
               w_state_nxt = S_HIT;
               w_capture   = 1'b1;
            end
         end
         S_HIT: begin
            if (bus.stu_now_hit) begin
               w_accum = bus.sm_vld;
            end else begin
               w_state_nxt = S_SEND;
               w_load      = 1'b1;
            end
         end
         S_SEND: begin
            // A rise landing on the final handshake starts the next hit with no gap.
            if (w_done && w_rise && bus.cfg_en) begin
               w_state_nxt = S_HIT;
               w_capture   = 1'b1;
            end else begin
               w_drop_inc = w_rise;
               if (w_done) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_d    <= 1'b0;
         r_last_smp <= '0;
         r_id       <= '0;
         r_peak     <= '0;
         r_dur      <= '0;
         r_drop     <= '0;
      end else begin
         r_hit_d <= bus.stu_now_hit;
         if (bus.sm_vld) r_last_smp <= bus.sm_data;
         if (w_drop_inc && (r_drop != DROP_MAX)) r_drop <= r_drop + 16'd1;
         if (w_capture) begin
            r_id   <= bus.stu_hit_id;
            r_peak <= bus.sm_vld ? umax16(r_last_smp, bus.sm_data) : r_last_smp;
            r_dur  <= {15'd0, bus.sm_vld};
         end else if (w_accum) begin
            r_peak <= umax16(r_peak, bus.sm_data);
            if (r_dur != 16'hFFFF) r_dur <= r_dur + 16'd1;
         end
      end
   end

   hit_rec_ser u_ser (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_id       (r_id),
      .i_peak     (r_peak),
      .i_dur      (r_dur),
`ifdef HIT_REC_TS_EN
      .i_ts       (r_ts_q),
`endif
      .i_rec_rdy  (bus.rec_rdy),
      .o_rec_data (bus.rec_data),
      .o_rec_vld  (bus.rec_vld),
      .o_rec_last (bus.rec_last),
      .o_done     (w_done)
   );

   assign bus.stu_rec_busy = r_busy;
   assign bus.stu_rec_drop = r_drop;

endmodule

// File: tb/tb_hit_record.sv
// Bench for hit_record: directed scenarios plus random traffic against a
// record-queue reference model; honours HIT_REC_TS_EN for record length.
module tb_hit_record;
   import hit_pkg::*;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;

   hit_record_if bus ();

   hit_record dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   // Reference model: register-level observables plus the record still owed.
   logic        m_hit_d;
   logic [15:0] m_last_smp;
   bit          m_in_hit;
   logic [15:0] m_id, m_peak, m_dur, m_drop;
   logic [15:0] m_q[$];
   logic [15:0] got[$];
`ifdef HIT_REC_TS_EN
   logic [31:0] m_ts, m_ts_q;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hit_d    = 1'b0;
      m_last_smp = '0;
      m_in_hit   = 1'b0;
      m_id       = '0;
      m_peak     = '0;
      m_dur      = '0;
      m_drop     = '0;
      m_q.delete();
`ifdef HIT_REC_TS_EN
      m_ts       = '0;
      m_ts_q     = '0;
`endif
   endtask

   task automatic drive(input logic [15:0] d, input logic v, input logic h);
      bus.sm_data     = d;
      bus.sm_vld      = v;
      bus.stu_now_hit = h;
   endtask

   task automatic cycle();
      bit rise, sending, done;
      @(negedge clk_sys);
      chk("rec_vld", bus.rec_vld, m_q.size() > 0);
      if (m_q.size() > 0) begin
         chk("rec_data", bus.rec_data, m_q[0]);
         chk("rec_last", bus.rec_last, m_q.size() == 1);
      end
      chk("busy", bus.stu_rec_busy, m_in_hit || (m_q.size() > 0));
      chk("drop", bus.stu_rec_drop, m_drop);
      if (bus.rec_vld && bus.rec_rdy) got.push_back(bus.rec_data);

      rise    = bus.stu_now_hit && !m_hit_d;
      sending = m_q.size() > 0;
      done    = sending && bus.rec_rdy && (m_q.size() == 1);
      if (sending && bus.rec_rdy) void'(m_q.pop_front());
      if (m_in_hit) begin
         if (bus.stu_now_hit) begin
            if (bus.sm_vld) begin
               if (bus.sm_data > m_peak) m_peak = bus.sm_data;
               if (m_dur != 16'hFFFF) m_dur = m_dur + 16'd1;
            end
         end else begin
            m_in_hit = 1'b0;
            m_q.push_back(m_id);
            m_q.push_back(m_peak);
            m_q.push_back(m_dur);
`ifdef HIT_REC_TS_EN
            m_q.push_back(m_ts_q[31:16]);
            m_q.push_back(m_ts_q[15:0]);
`endif
         end
      end else if ((!sending || done) && rise && bus.cfg_en) begin
         m_in_hit = 1'b1;
         m_id     = bus.stu_hit_id;
         m_peak   = m_last_smp;
         if (bus.sm_vld && bus.sm_data > m_peak) m_peak = bus.sm_data;
         m_dur    = {15'd0, bus.sm_vld};
`ifdef HIT_REC_TS_EN
         m_ts_q   = m_ts;
`endif
      end else if (sending && rise && m_drop != 16'hFFFF) begin
         m_drop = m_drop + 16'd1;
      end
      m_hit_d = bus.stu_now_hit;
      if (bus.sm_vld) m_last_smp = bus.sm_data;
`ifdef HIT_REC_TS_EN
      m_ts = m_ts + 32'd1;
`endif
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(16'd0, 1'b0, 1'b0);
         cycle();
      end
   endtask

   initial begin
      model_reset();
      bus.cfg_en     = 1'b1;
      bus.rec_rdy    = 1'b1;
      bus.stu_hit_id = 16'd5;
      drive(16'd0, 1'b0, 1'b0);
      #1;
      chk("rst_vld", bus.rec_vld, 1'b0);
      chk("rst_last", bus.rec_last, 1'b0);
      chk("rst_data", bus.rec_data, 16'd0);
      chk("rst_busy", bus.stu_rec_busy, 1'b0);
      chk("rst_drop", bus.stu_rec_drop, 16'd0);
      repeat (2) @(posedge clk_sys);
      #1;
      rst_n = 1'b1;

      // Single hit: rise on 1500 with last_smp=900, three valid samples.
      got.delete();
      drive(16'd100, 1'b1, 1'b0);  cycle();
      drive(16'd900, 1'b1, 1'b0);  cycle();
      drive(16'd1500, 1'b1, 1'b1); cycle();
      drive(16'd700, 1'b1, 1'b1);  cycle();
      drive(16'd300, 1'b1, 1'b1);  cycle();
      drive(16'd9000, 1'b1, 1'b0); cycle();
      idle(8);
      chk("single_len", got.size(), REC_LEN);
      if (got.size() >= 3) begin
         chk("single_id", got[0], 16'd5);
         chk("single_peak", got[1], 16'd1500);
         chk("single_dur", got[2], 16'd3);
      end

      // Backpressure: rdy toggles every cycle.
      got.delete();
      bus.stu_hit_id = 16'h0A0B;
      for (int i = 0; i < 24; i++) begin
         bus.rec_rdy = i[0];
         drive(16'($urandom), 1'b1, i < 4);
         cycle();
      end
      bus.rec_rdy = 1'b1;
      idle(4);
      chk("bp_len", got.size(), REC_LEN);
      if (got.size() >= 3) chk("bp_dur", got[2], 16'd4);

      // Drop: two rises while the record is stalled.
      got.delete();
      bus.rec_rdy    = 1'b0;
      bus.stu_hit_id = 16'd77;
      drive(16'd10, 1'b1, 1'b1); cycle();
      drive(16'd20, 1'b1, 1'b1); cycle();
      drive(16'd30, 1'b1, 1'b0); cycle();
      drive(16'd40, 1'b1, 1'b1); cycle();
      drive(16'd50, 1'b1, 1'b0); cycle();
      drive(16'd60, 1'b1, 1'b1); cycle();
      drive(16'd70, 1'b1, 1'b0); cycle();
      chk("drop_two", bus.stu_rec_drop, 16'd2);
      bus.rec_rdy = 1'b1;
      idle(10);
      chk("drop_len", got.size(), REC_LEN);
      if (got.size() >= 1) chk("drop_id", got[0], 16'd77);

      // Coincident rise on the final-word handshake.
      got.delete();
      bus.stu_hit_id = 16'd123;
      drive(16'd5, 1'b1, 1'b1); cycle();
      drive(16'd6, 1'b1, 1'b1); cycle();
      for (int i = 0; i < int'(REC_LEN); i++) begin
         drive(16'd7, 1'b1, 1'b0);
         cycle();
      end
      bus.stu_hit_id = 16'd124;
      drive(16'd8, 1'b1, 1'b1); cycle();
      chk("coin_busy", bus.stu_rec_busy, 1'b1);
      drive(16'd9, 1'b1, 1'b1); cycle();
      idle(10);
      chk("coin_drop", bus.stu_rec_drop, 16'd2);
      chk("coin_len", got.size(), 2 * REC_LEN);
      if (got.size() == 2 * REC_LEN) chk("coin_id2", got[REC_LEN], 16'd124);

      // Duration saturation.
      got.delete();
      for (int i = 0; i < 70000; i++) begin
         drive(16'($urandom_range(0, 1000)), 1'b1, 1'b1);
         cycle();
      end
      idle(8);
      chk("sat_len", got.size(), REC_LEN);
      if (got.size() >= 3) chk("sat_dur", got[2], 16'hFFFF);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) bus.stu_now_hit = ~bus.stu_now_hit;
         bus.sm_vld     = 1'($urandom_range(0, 1));
         bus.sm_data    = 16'($urandom);
         bus.rec_rdy    = ($urandom_range(0, 3) != 0);
         bus.cfg_en     = ($urandom_range(0, 7) != 0);
         bus.stu_hit_id = 16'($urandom);
         cycle();
      end
      bus.cfg_en  = 1'b1;
      bus.rec_rdy = 1'b1;
      idle(12);

      // Reset asserted while word 1 is presented.
      drive(16'd11, 1'b1, 1'b1); cycle();
      drive(16'd12, 1'b1, 1'b1); cycle();
      drive(16'd13, 1'b1, 1'b0); cycle();
      cycle();
      bus.rec_rdy = 1'b0;
      cycle();
      chk("mid_vld", bus.rec_vld, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", bus.rec_vld, 1'b0);
      chk("mid_rst_last", bus.rec_last, 1'b0);
      chk("mid_rst_data", bus.rec_data, 16'd0);
      chk("mid_rst_busy", bus.stu_rec_busy, 1'b0);
      chk("mid_rst_drop", bus.stu_rec_drop, 16'd0);
      model_reset();
      drive(16'd0, 1'b0, 1'b0);
      bus.rec_rdy = 1'b1;
      @(posedge clk_sys);
      #1;
      rst_n = 1'b1;

      // Rise with capture disabled: no record, no drop.
      got.delete();
      bus.cfg_en = 1'b0;
      drive(16'd99, 1'b1, 1'b1); cycle();
      drive(16'd98, 1'b1, 1'b1); cycle();
      idle(8);
      chk("dis_len", got.size(), 0);
      chk("dis_drop", bus.stu_rec_drop, 16'd0);
      chk("dis_busy", bus.stu_rec_busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
